// File: rtl/alu_exec.sv
// alu_exec: multi-cycle execute-stage ALU. Single-cycle logic/arithmetic ops;
// SLL/SRL run iteratively one bit per cycle. Latency: 1 cycle from the
// accepting edge, or 1 + shamt cycles for shifts with shamt > 0.
// Backpressure: start is accepted only when idle; starts while busy are dropped.
// Ports: clk, rst_n (async active-low); start/alu_ctrl/a/b/shamt request;
//        busy, done (1-cycle pulse), result/zero/overflow (registered).
module alu_exec #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state, state_nxt;

  // Operands captured on the accepting edge; the op executes one edge later.
  logic             pend_vld;
  logic [3:0]       op_ctrl;
  logic [WIDTH-1:0] op_a, op_b;
  logic [SHW-1:0]   op_shamt;

  logic [WIDTH-1:0] sh_reg, sh_next;
  logic [SHW-1:0]   cnt;
  logic             dir_right;

  logic             pend_shift;
  logic             accept, finish_alu, load_shift, finish_shift;
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             ovf_add, ovf_sub, alu_ovf;

  assign pend_shift = pend_vld && (op_ctrl == 4'h4 || op_ctrl == 4'h5) && (op_shamt != '0);

  assign sum     = op_a + op_b;
  assign diff    = op_a - op_b;
  assign ovf_add = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1]  != op_a[WIDTH-1]);
  assign ovf_sub = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);

  assign sh_next = dir_right ? (sh_reg >> 1) : (sh_reg << 1);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_ctrl)
      4'h0: begin alu_res = sum;  alu_ovf = ovf_add; end
      4'h1: begin alu_res = diff; alu_ovf = ovf_sub; end
      4'h2: alu_res = op_a & op_b;
      4'h3: alu_res = op_a | op_b;
      // Shifts only take this path when shamt == 0, so the result is b unchanged.
      4'h4, 4'h5: alu_res = op_b;
      // Sign of (a - b) corrected by its overflow gives the true signed compare.
      4'h6: alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ ovf_sub};
      4'h7: begin alu_res = diff; alu_ovf = ovf_sub; end
      4'h8: alu_res = {op_b[15:0], {(WIDTH-16){1'b0}}};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    finish_alu   = 1'b0;
    load_shift   = 1'b0;
    finish_shift = 1'b0;
    case (state)
      IDLE: begin
        // A pending shift has already committed the block, so a new start is dropped.
        accept = start && !pend_shift;
        if (pend_shift) begin
          load_shift = 1'b1;
          state_nxt  = SHIFT;
        end else if (pend_vld) begin
          finish_alu = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt == SHW'(1)) begin
          finish_shift = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld  <= 1'b0;
      op_ctrl   <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_shamt  <= '0;
      sh_reg    <= '0;
      cnt       <= '0;
      dir_right <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done     <= 1'b0;
      pend_vld <= accept;
      if (accept) begin
        op_ctrl  <= alu_ctrl;
        op_a     <= a;
        op_b     <= b;
        op_shamt <= shamt;
      end
      if (finish_alu) begin
        result   <= alu_res;
        zero     <= (alu_res == '0);
        overflow <= alu_ovf;
        done     <= 1'b1;
      end
      if (load_shift) begin
        sh_reg    <= op_b;
        cnt       <= op_shamt;
        dir_right <= (op_ctrl == 4'h5);
        busy      <= 1'b1;
      end
      if (state == SHIFT) begin
        sh_reg <= sh_next;
        cnt    <= cnt - SHW'(1);
        if (finish_shift) begin
          result   <= sh_next;
          zero     <= (sh_next == '0);
          overflow <= 1'b0;
          done     <= 1'b1;
          busy     <= 1'b0;
        end
      end
    end
  end

endmodule
